// File: rtl/w_stage_writeback.sv
// w_stage_writeback: W-stage decode, 32x32 GRF commit with read bypass, forwarding triple and commit trace
module w_stage_writeback #(
  parameter int          REG_NUM        = 32,
  parameter logic [31:0] PC_LINK_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] w_instr,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_alu_out,
  input  logic [31:0] w_dm_out,
  input  logic [31:0] w_ext_out,
  input  logic        w_cmp_out,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic        w_we,
  output logic [4:0]  w_dst,
  output logic [31:0] w_wd,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_reg,
  output logic [31:0] trace_data
);
  logic [31:0] grf [REG_NUM];
  logic [5:0]  op, fn;
  logic        r_alu, r_jalr, i_alu, i_lui, i_slt, i_ld, i_jal, dec;
  logic [4:0]  dst;
  logic [31:0] wd, link;
  // decode destination and result source, then gate by $0 suppression
  always_comb begin
    op     = w_instr[31:26];
    fn     = w_instr[5:0];
    r_alu  = op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h2B);
    r_jalr = op == 6'h00 && fn == 6'h09;
    i_alu  = op == 6'h09 || op == 6'h0C || op == 6'h0D;
    i_lui  = op == 6'h0F;
    i_slt  = op == 6'h0A || op == 6'h0B;
    i_ld   = op == 6'h20 || op == 6'h21 || op == 6'h23 || op == 6'h24 || op == 6'h25;
    i_jal  = op == 6'h03;
    dec    = r_alu || r_jalr || i_alu || i_lui || i_slt || i_ld || i_jal;
    link   = w_pc + PC_LINK_OFFSET;
    dst    = i_jal ? 5'd31 : (r_alu || r_jalr) ? w_instr[15:11] : w_instr[20:16];
    wd     = (i_jal || r_jalr) ? link : i_lui ? w_ext_out : i_slt ? {31'b0, w_cmp_out} : i_ld ? w_dm_out : w_alu_out;
    w_we   = dec && dst != 5'd0;
    w_dst  = w_we ? dst : 5'd0;
    w_wd   = w_we ? wd : 32'd0;
  end
  // read ports with same-cycle writeback bypass; $0 is hardwired to zero
  always_comb begin
    rs_data = rs_addr == 5'd0 ? 32'd0 : (w_we && w_dst == rs_addr) ? w_wd : grf[rs_addr];
    rt_data = rt_addr == 5'd0 ? 32'd0 : (w_we && w_dst == rt_addr) ? w_wd : grf[rt_addr];
  end
  // register file commit; reset clears every entry and drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_NUM; i++) grf[i] <= 32'd0;
    end else if (w_we) begin
      grf[w_dst] <= w_wd;
    end
  end
  // one-cycle commit trace, zeroed when nothing committed
  always_ff @(posedge clk) begin
    if (reset) begin
      trace_valid <= 1'b0;
      trace_pc    <= 32'd0;
      trace_reg   <= 5'd0;
      trace_data  <= 32'd0;
    end else begin
      trace_valid <= w_we;
      trace_pc    <= w_we ? w_pc : 32'd0;
      trace_reg   <= w_dst;
      trace_data  <= w_wd;
    end
  end
endmodule

// File: tb/tb_w_stage_writeback.sv
// tb_w_stage_writeback: scoreboard bench for the writeback stage and GRF
module tb_w_stage_writeback;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] w_instr = '0, w_pc = '0, w_alu_out = '0, w_dm_out = '0, w_ext_out = '0;
  logic        w_cmp_out = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data, rt_data, w_wd, trace_pc, trace_data;
  logic        w_we, trace_valid;
  logic [4:0]  w_dst, trace_reg;
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m [32];
  typedef struct packed {
    logic        rst;
    logic        v;
    logic [31:0] pc;
    logic [4:0]  r;
    logic [31:0] d;
  } tr_t;
  tr_t q [$];

  w_stage_writeback dut (
    .clk(clk), .reset(reset), .w_instr(w_instr), .w_pc(w_pc), .w_alu_out(w_alu_out),
    .w_dm_out(w_dm_out), .w_ext_out(w_ext_out), .w_cmp_out(w_cmp_out),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .w_we(w_we), .w_dst(w_dst), .w_wd(w_wd), .trace_valid(trace_valid),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, pc, alu, dm, ex, input logic cmp, rst,
                       input logic we_e, input logic [4:0] dst_e, input logic [31:0] wd_e);
    tr_t e;
    w_instr = ins; w_pc = pc; w_alu_out = alu; w_dm_out = dm; w_ext_out = ex; w_cmp_out = cmp; reset = rst;
    #1;
    chk("w_we", {31'b0, w_we}, {31'b0, we_e});
    chk("w_dst", {27'b0, w_dst}, we_e ? {27'b0, dst_e} : 32'd0);
    chk("w_wd", w_wd, we_e ? wd_e : 32'd0);
    e.rst = rst;
    e.v   = !rst && we_e;
    e.pc  = e.v ? pc : 32'd0;
    e.r   = e.v ? dst_e : 5'd0;
    e.d   = e.v ? wd_e : 32'd0;
    q.push_back(e);
  endtask

  task automatic tick();
    tr_t e;
    @(posedge clk);
    #1;
    reset = 1'b0;
    w_instr = 32'd0;
    if (q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      chk("trace_valid", {31'b0, trace_valid}, {31'b0, e.v});
      chk("trace_pc", trace_pc, e.pc);
      chk("trace_reg", {27'b0, trace_reg}, {27'b0, e.r});
      chk("trace_data", trace_data, e.d);
      if (e.rst) for (int i = 0; i < 32; i++) m[i] = 32'd0;
      else if (e.v) m[e.r] = e.d;
    end
  endtask

  task automatic rd(input logic [4:0] a, b);
    rs_addr = a; rt_addr = b;
    #1;
    chk($sformatf("rs[%0d]", a), rs_data, m[a]);
    chk($sformatf("rt[%0d]", b), rt_data, m[b]);
  endtask

  task automatic rd_all();
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    drive(32'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    rd_all();
    chk("trace_valid_rst", {31'b0, trace_valid}, 32'd0);
    drive(32'h34051234, 32'h100, 32'h1234, 0, 0, 0, 0, 1, 5, 32'h1234); tick();
    rd(5, 0);
    drive(32'h0C000C00, 32'h3000, 32'h99, 0, 0, 0, 0, 1, 31, 32'h3008); tick();
    rd(31, 5);
    drive(32'h03E00009, 32'h4444, 32'h1, 0, 0, 0, 0, 0, 0, 0); tick();
    rs_addr = 8; rt_addr = 8;
    drive(32'h8C080000, 32'h200, 32'h11, 32'hDEADBEEF, 0, 0, 0, 1, 8, 32'hDEADBEEF);
    chk("rs_bypass", rs_data, 32'hDEADBEEF);
    chk("rt_bypass", rt_data, 32'hDEADBEEF);
    tick();
    rd(8, 8);
    drive(32'h2C090001, 32'h204, 32'h55, 0, 0, 1, 0, 1, 9, 32'h1); tick();
    rd(9, 0);
    rs_addr = 0; rt_addr = 9;
    drive(32'h00000021, 32'h208, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0);
    chk("rs_zero_nowrite", rs_data, 32'd0);
    tick();
    rd(0, 0);
    drive(32'h00A63023, 32'h20C, 32'h77, 0, 0, 0, 0, 1, 6, 32'h77); tick();
    drive(32'h0000382A, 32'h210, 32'h1, 0, 0, 0, 0, 1, 7, 32'h1); tick();
    drive(32'h800A0000, 32'h214, 0, 32'hFFFFFF80, 0, 0, 0, 1, 10, 32'hFFFFFF80); tick();
    drive(32'hFC000000, 32'h218, 32'h5A5A, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(32'h0C000000, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 1, 31, 32'h4); tick();
    rd_all();
    drive(32'h3C04ABCD, 32'h300, 0, 0, 32'hABCD0000, 0, 1, 1, 4, 32'hABCD0000); tick();
    rd_all();
    chk("trace_valid_after_rst", {31'b0, trace_valid}, 32'd0);
    drive(32'h24070001, 32'h400, 32'h1, 0, 0, 0, 0, 1, 7, 32'h1); tick();
    drive(32'h24070002, 32'h404, 32'h2, 0, 0, 0, 0, 1, 7, 32'h2); tick();
    rd(7, 7);
    rs_addr = 7; rt_addr = 3;
    drive(32'h3C07BEEF, 32'h408, 0, 0, 32'hBEEF0000, 0, 0, 1, 7, 32'hBEEF0000);
    chk("rs_bypass_stale", rs_data, 32'hBEEF0000);
    chk("rt_nobypass", rt_data, 32'd0);
    tick();
    drive(32'h00002809, 32'h500, 0, 0, 0, 0, 0, 1, 5, 32'h508); tick();
    rd_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
